// File: rtl/axi_arb_pkg.sv
// Shared types and response codes for the AXI4-Lite request arbiter.
// Also holds the slave-response to reported-code mapping.
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // Any non-OKAY slave response is reported to the requester as SLVERR.
  function automatic logic [1:0] map_resp(input logic [1:0] i_resp);
    return (i_resp == RESP_OKAY) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first set request
// found searching upward from i_ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt
);

  logic [PtrW-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = i_ptr;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (w_idx == PtrW'(N - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one AXI4-Lite master command port among NREQ requesters, one
// transaction at a time, completing on the monitored B/R handshakes.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic [1:0]               resp_code,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     bvalid,
  input  logic                     bready,
  input  logic [1:0]               bresp,
  input  logic                     rvalid,
  input  logic                     rready,
  input  logic [1:0]               rresp,
  output logic                     busy,
  output logic                     timeout_flag
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT);

  state_t              r_state;
  logic [PtrW-1:0]     r_rr_ptr;
  logic [PtrW-1:0]     r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [TmrW-1:0]     r_timer;
  logic                r_wr_en;
  logic                r_rd_en;
  logic [NREQ-1:0]     r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [1:0]          r_resp_code;
  logic                r_timeout_flag;

  logic [NREQ-1:0]     w_gnt;
  logic [PtrW-1:0]     w_win_idx;
  logic                w_done;
  logic                w_expire;

  rr_arbiter #(
    .N    (NREQ),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_win_idx = PtrW'(i);
    end
  end

  // Only the channel matching the captured op can complete the transaction.
  assign w_done   = r_we ? (bvalid & bready) : (rvalid & rready);
  assign w_expire = (r_timer == TmrW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rr_ptr       <= PtrW'(NREQ - 1);
      r_idx          <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_timer        <= '0;
      r_wr_en        <= 1'b0;
      r_rd_en        <= 1'b0;
      r_resp_valid   <= '0;
      r_resp_rdata   <= '0;
      r_resp_code    <= RESP_OKAY;
      r_timeout_flag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_idx   <= w_win_idx;
            r_we    <= req_we[w_win_idx];
            r_addr  <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[w_win_idx*DATA_W +: DATA_W];
            r_wr_en <= req_we[w_win_idx];
            r_rd_en <= !req_we[w_win_idx];
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_wr_en <= 1'b0;
          r_rd_en <= 1'b0;
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            r_resp_valid <= NREQ'(1) << r_idx;
            r_resp_rdata <= r_we ? '0 : rd_data;
            r_resp_code  <= map_resp(r_we ? bresp : rresp);
            r_state      <= RESP;
          end else if (w_expire) begin
            r_resp_valid   <= NREQ'(1) << r_idx;
            r_resp_rdata   <= '0;
            r_resp_code    <= RESP_TIMEOUT;
            r_timeout_flag <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          r_resp_valid <= '0;
          r_resp_rdata <= '0;
          r_resp_code  <= RESP_OKAY;
          r_rr_ptr     <= r_idx;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant is combinational but suppressed while reset is held.
  assign req_ready    = (r_state == IDLE && !rst) ? w_gnt : '0;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_code    = r_resp_code;
  assign wr_en        = r_wr_en;
  assign rd_en        = r_rd_en;
  assign wr_addr      = r_addr;
  assign rd_addr      = r_addr;
  assign wr_data      = r_wdata;
  assign busy         = (r_state != IDLE);
  assign timeout_flag = r_timeout_flag;

endmodule
